// File: rtl/taptempo_pkg.sv
// ---------------------------------------------------------------------------
// taptempo_pkg
// Shared constants, width helpers and FSM encoding for the TapTempo datapath.
//   MIN_NS         : nanoseconds per minute
//   calc_dividend  : BPM numerator for a given tick size and clock period
//   calc_per_w     : width needed to hold a tap period in ticks
//   calc_bpm_w     : width needed to hold a BPM value up to bpm_max
//   state_e        : converter FSM states
// ---------------------------------------------------------------------------
package taptempo_pkg;

    localparam longint unsigned MIN_NS = 64'd60_000_000_000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_AVG,
        ST_DIV,
        ST_DONE
    } state_e;

    // BPM = MIN_NS / (period_ticks * tp_cycle * clk_per_ns), so the
    // constant numerator absorbs everything except the period itself.
    function automatic longint unsigned calc_dividend(input int tp_cycle, input int clk_per_ns);
        return MIN_NS / (64'(tp_cycle) * 64'(clk_per_ns));
    endfunction

    function automatic int calc_per_w(input longint unsigned dividend);
        return $clog2(dividend + 1);
    endfunction

    function automatic int calc_bpm_w(input int bpm_max);
        return $clog2(bpm_max + 1);
    endfunction

endpackage

// File: rtl/udiv_restoring.sv
// ---------------------------------------------------------------------------
// udiv_restoring
// Unsigned restoring divider, one quotient bit per clock, MSB first.
//   clk_i, rst_n_i : clock, synchronous active-low reset
//   start_i        : load dividend/divisor and begin (ignored bits in flight
//                    are discarded)
//   dividend_i     : N_W-bit numerator
//   divisor_i      : D_W-bit denominator (zero yields an all-ones quotient)
//   done_o         : high during the final step; quotient_o is complete from
//                    the following cycle until the next start
//   quotient_o     : N_W-bit quotient
// ---------------------------------------------------------------------------
module udiv_restoring #(
    parameter int N_W = 20,
    parameter int D_W = 19
) (
    input  logic           clk_i,
    input  logic           rst_n_i,
    input  logic           start_i,
    input  logic [N_W-1:0] dividend_i,
    input  logic [D_W-1:0] divisor_i,
    output logic           done_o,
    output logic [N_W-1:0] quotient_o
);

    localparam int CNT_W = $clog2(N_W + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N_W - 1);

    logic             busy_q, busy_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N_W-1:0]   quo_q, quo_d;   // dividend bits leave at the top, quotient bits enter at the bottom
    logic [D_W-1:0]   rem_q, rem_d;
    logic [D_W-1:0]   dvs_q, dvs_d;
    logic [D_W:0]     rem_shift;
    logic             fits;

    // NOTE: every variable written here gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        busy_d    = busy_q;
        cnt_d     = cnt_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        dvs_d     = dvs_q;
        rem_shift = {rem_q, quo_q[N_W-1]};
        fits      = (rem_shift >= {1'b0, dvs_q});
        if (start_i) begin
            busy_d = 1'b1;
            cnt_d  = '0;
            quo_d  = dividend_i;
            rem_d  = '0;
            dvs_d  = divisor_i;
        end else if (busy_q) begin
            // Partial remainder stays below the divisor, so it always fits D_W bits.
            rem_d = fits ? D_W'(rem_shift - {1'b0, dvs_q}) : D_W'(rem_shift);
            quo_d = {quo_q[N_W-2:0], fits};
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
                busy_d = 1'b0;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            quo_q  <= '0;
            rem_q  <= '0;
            dvs_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            quo_q  <= quo_d;
            rem_q  <= rem_d;
            dvs_q  <= dvs_d;
        end
    end

    assign done_o     = busy_q && (cnt_q == LAST);
    assign quotient_o = quo_q;

endmodule

// File: rtl/per2bpm_avg.sv
// ---------------------------------------------------------------------------
// per2bpm_avg
// Moving-average tap period to BPM converter with clamping.
//   clk_i, rst_n_i   : clock, synchronous active-low reset
//   btn_per_i        : tap period in ticks (valid/ready handshake)
//   btn_per_valid_i  : period available
//   btn_per_ready_o  : block can accept a period (IDLE only)
//   clear_i          : flush averaging history (deferred while busy)
//   bpm_o            : last computed BPM, held between results
//   bpm_valid_o      : one-cycle pulse with a new bpm_o
//   sat_hi_o         : last result clamped to BPM_MAX (also divide-by-zero)
//   sat_lo_o         : last result clamped to BPM_MIN
//   busy_o           : computation in progress
// Latency: handshake edge to bpm_valid_o is PER_W+3 cycles.
// ---------------------------------------------------------------------------
module per2bpm_avg
    import taptempo_pkg::*;
#(
    parameter int CLK_PER_NS = 40,
    parameter int TP_CYCLE   = 5120,
    parameter int BPM_MAX    = 250,
    parameter int BPM_MIN    = 30,
    parameter int AVG_DEPTH  = 4,
    parameter int ROUND      = 1,
    localparam longint unsigned DIVIDEND = calc_dividend(TP_CYCLE, CLK_PER_NS),
    localparam int PER_W = calc_per_w(DIVIDEND),
    localparam int BPM_W = calc_bpm_w(BPM_MAX)
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [PER_W-1:0] btn_per_i,
    input  logic             btn_per_valid_i,
    output logic             btn_per_ready_o,
    input  logic             clear_i,
    output logic [BPM_W-1:0] bpm_o,
    output logic             bpm_valid_o,
    output logic             sat_hi_o,
    output logic             sat_lo_o,
    output logic             busy_o
);

    localparam int LOG2_D = $clog2(AVG_DEPTH);
    localparam int PTR_W  = (LOG2_D > 0) ? LOG2_D : 1;
    localparam int SUM_W  = PER_W + LOG2_D;
    localparam int DIV_W  = PER_W + 1;   // extra bit absorbs the rounding addend

    localparam logic [DIV_W-1:0] DIVIDEND_V  = DIV_W'(DIVIDEND);
    localparam logic [DIV_W-1:0] BPM_MAX_Q   = DIV_W'(BPM_MAX);
    localparam logic [DIV_W-1:0] BPM_MIN_Q   = DIV_W'(BPM_MIN);
    localparam logic [BPM_W-1:0] BPM_MAX_B   = BPM_W'(BPM_MAX);
    localparam logic [BPM_W-1:0] BPM_MIN_B   = BPM_W'(BPM_MIN);
    localparam logic [PTR_W-1:0] PTR_PREFILL = PTR_W'((AVG_DEPTH > 1) ? 1 : 0);

    state_e           state_q, state_d;
    logic [PER_W-1:0] hist_q [AVG_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, wr_ptr_inc;
    logic [SUM_W-1:0] sum_q, sum_d;
    logic             hist_vld_q, hist_vld_d;
    logic             clr_pend_q, clr_pend_d;
    logic             div0_q, div0_d;
    logic [BPM_W-1:0] bpm_q, bpm_d;
    logic             sat_hi_q, sat_hi_d;
    logic             sat_lo_q, sat_lo_d;

    logic             accept;
    logic             hist_empty;
    logic [PER_W-1:0] avg;
    logic [DIV_W-1:0] div_dividend;
    logic             div_done;
    logic [DIV_W-1:0] quotient;
    logic [BPM_W-1:0] clamp_bpm;
    logic             clamp_hi, clamp_lo;

    assign accept     = btn_per_valid_i && (state_q == ST_IDLE);
    // A clear arriving with a sample is applied first, so the sample prefills.
    assign hist_empty = !hist_vld_q || clear_i;
    assign wr_ptr_inc = (AVG_DEPTH > 1) ? wr_ptr_q + 1'b1 : '0;
    assign avg        = sum_q[SUM_W-1:LOG2_D];
    assign div_dividend = DIVIDEND_V + ((ROUND != 0) ? DIV_W'(avg >> 1) : '0);

    udiv_restoring #(
        .N_W (DIV_W),
        .D_W (PER_W)
    ) u_div (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .start_i    (state_q == ST_AVG),
        .dividend_i (div_dividend),
        .divisor_i  (avg),
        .done_o     (div_done),
        .quotient_o (quotient)
    );

    always_comb begin
        clamp_bpm = quotient[BPM_W-1:0];
        clamp_hi  = 1'b0;
        clamp_lo  = 1'b0;
        if (div0_q || (quotient > BPM_MAX_Q)) begin
            clamp_bpm = BPM_MAX_B;
            clamp_hi  = 1'b1;
        end else if (quotient < BPM_MIN_Q) begin
            clamp_bpm = BPM_MIN_B;
            clamp_lo  = 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        sum_d      = sum_q;
        hist_vld_d = hist_vld_q;
        clr_pend_d = clr_pend_q;
        div0_d     = div0_q;
        bpm_d      = bpm_q;
        sat_hi_d   = sat_hi_q;
        sat_lo_d   = sat_lo_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d    = ST_AVG;
                    hist_vld_d = 1'b1;
                    if (hist_empty) begin
                        sum_d    = SUM_W'(btn_per_i) << LOG2_D;
                        wr_ptr_d = PTR_PREFILL;
                    end else begin
                        // Modular arithmetic: the true result is never negative.
                        sum_d    = sum_q + SUM_W'(btn_per_i) - SUM_W'(hist_q[wr_ptr_q]);
                        wr_ptr_d = wr_ptr_inc;
                    end
                end else if (clear_i) begin
                    hist_vld_d = 1'b0;
                end
            end
            ST_AVG: begin
                state_d = ST_DIV;
                div0_d  = (avg == '0);
            end
            ST_DIV: begin
                if (div_done) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d  = ST_IDLE;
                bpm_d    = clamp_bpm;
                sat_hi_d = clamp_hi;
                sat_lo_d = clamp_lo;
                if (clr_pend_q || clear_i) begin
                    hist_vld_d = 1'b0;
                end
                clr_pend_d = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase
        if (((state_q == ST_AVG) || (state_q == ST_DIV)) && clear_i) begin
            clr_pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= '0;
            sum_q      <= '0;
            hist_vld_q <= 1'b0;
            clr_pend_q <= 1'b0;
            div0_q     <= 1'b0;
            bpm_q      <= '0;
            sat_hi_q   <= 1'b0;
            sat_lo_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            sum_q      <= sum_d;
            hist_vld_q <= hist_vld_d;
            clr_pend_q <= clr_pend_d;
            div0_q     <= div0_d;
            bpm_q      <= bpm_d;
            sat_hi_q   <= sat_hi_d;
            sat_lo_q   <= sat_lo_d;
        end
    end

    // NOTE: the history array has no reset; hist_vld_q marks it empty and the next sample prefills every entry.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            if (hist_empty) begin
                for (int i = 0; i < AVG_DEPTH; i++) begin
                    hist_q[i] <= btn_per_i;
                end
            end else begin
                hist_q[wr_ptr_q] <= btn_per_i;
            end
        end
    end

    assign btn_per_ready_o = (state_q == ST_IDLE);
    assign busy_o          = (state_q != ST_IDLE);
    assign bpm_valid_o     = (state_q == ST_DONE);
    // The fresh result is visible in DONE itself and held from then on.
    assign bpm_o           = bpm_valid_o ? clamp_bpm : bpm_q;
    assign sat_hi_o        = bpm_valid_o ? clamp_hi  : sat_hi_q;
    assign sat_lo_o        = bpm_valid_o ? clamp_lo  : sat_lo_q;

endmodule

// File: tb/tb_per2bpm_avg.sv
module tb_per2bpm_avg;

    localparam int CLK_PER_NS = 40;
    localparam int TP_CYCLE   = 5120;
    localparam int BPM_MAX    = 250;
    localparam int BPM_MIN    = 30;
    localparam int DEPTH      = 4;
    localparam int ROUND      = 1;
    localparam longint DIVIDEND = 64'd60_000_000_000 / (64'(TP_CYCLE) * 64'(CLK_PER_NS));
    localparam int PER_W = $clog2(DIVIDEND + 1);
    localparam int BPM_W = $clog2(BPM_MAX + 1);
    localparam int LAT   = PER_W + 3;   // handshake cycle 0 -> result cycle

    logic             clk_i = 1'b0;
    logic             rst_n_i = 1'b0;
    logic [PER_W-1:0] btn_per_i = '0;
    logic             btn_per_valid_i = 1'b0;
    logic             btn_per_ready_o;
    logic             clear_i = 1'b0;
    logic [BPM_W-1:0] bpm_o;
    logic             bpm_valid_o;
    logic             sat_hi_o;
    logic             sat_lo_o;
    logic             busy_o;

    per2bpm_avg #(
        .CLK_PER_NS (CLK_PER_NS),
        .TP_CYCLE   (TP_CYCLE),
        .BPM_MAX    (BPM_MAX),
        .BPM_MIN    (BPM_MIN),
        .AVG_DEPTH  (DEPTH),
        .ROUND      (ROUND)
    ) dut (
        .clk_i           (clk_i),
        .rst_n_i         (rst_n_i),
        .btn_per_i       (btn_per_i),
        .btn_per_valid_i (btn_per_valid_i),
        .btn_per_ready_o (btn_per_ready_o),
        .clear_i         (clear_i),
        .bpm_o           (bpm_o),
        .bpm_valid_o     (bpm_valid_o),
        .sat_hi_o        (sat_hi_o),
        .sat_lo_o        (sat_lo_o),
        .busy_o          (busy_o)
    );

    always #(CLK_PER_NS / 2) clk_i = ~clk_i;

    // ---------------- bookkeeping and model state ----------------
    longint cyc = 0;            // rising edges seen so far
    int     tests = 0;
    int     fails = 0;
    bit     chk_en = 1'b0;
    longint hs_cyc = -1000;     // edge number of the last accepted handshake
    int     pend_bpm = 0;
    bit     pend_hi = 1'b0, pend_lo = 1'b0;
    int     held_bpm = 0;
    bit     held_hi = 1'b0, held_lo = 1'b0;
    int     hist[$];
    bit     clr_pend = 1'b0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at edge %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    // BPM from the average period, straight from the arithmetic definition.
    function automatic void ref_bpm(input longint avg, output int bpm, output bit hi, output bit lo);
        longint q;
        hi = 1'b0;
        lo = 1'b0;
        if (avg == 0) begin
            bpm = BPM_MAX;
            hi  = 1'b1;
            return;
        end
        q = (DIVIDEND + ((ROUND != 0) ? avg / 2 : 0)) / avg;
        if (q > BPM_MAX) begin
            bpm = BPM_MAX;
            hi  = 1'b1;
        end else if (q < BPM_MIN) begin
            bpm = BPM_MIN;
            lo  = 1'b1;
        end else begin
            bpm = int'(q);
        end
    endfunction

    task automatic model_accept(input int per, input bit clr);
        longint sum = 0;
        if (clr || clr_pend || hist.size() == 0) begin
            hist.delete();
            for (int i = 0; i < DEPTH; i++) hist.push_back(per);
        end else begin
            void'(hist.pop_front());
            hist.push_back(per);
        end
        clr_pend = 1'b0;
        foreach (hist[i]) sum += hist[i];
        ref_bpm(sum / DEPTH, pend_bpm, pend_hi, pend_lo);
        hs_cyc = cyc + 1;
    endtask

    task automatic model_reset();
        hs_cyc   = -1000;
        held_bpm = 0;
        held_hi  = 1'b0;
        held_lo  = 1'b0;
        hist.delete();
        clr_pend = 1'b0;
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clk_i) begin : cmp
        bit busy_e, vld_e;
        if (chk_en) begin
            busy_e = (cyc >= hs_cyc) && (cyc <= hs_cyc + LAT - 1);
            vld_e  = (cyc == hs_cyc + LAT - 1);
            check("ready", btn_per_ready_o, !busy_e);
            check("busy", busy_o, busy_e);
            check("bpm_valid", bpm_valid_o, vld_e);
            if (vld_e) begin
                held_bpm = pend_bpm;
                held_hi  = pend_hi;
                held_lo  = pend_lo;
            end
            check("bpm", bpm_o, held_bpm);
            check("sat_hi", sat_hi_o, held_hi);
            check("sat_lo", sat_lo_o, held_lo);
        end
    end

    // ---------------- drivers ----------------
    task automatic step();
        @(negedge clk_i);
        #2;
    endtask

    task automatic send(input int per, input bit clr);
        int budget = 0;
        btn_per_i       = PER_W'(per);
        btn_per_valid_i = 1'b1;
        while (!btn_per_ready_o && budget < 4 * LAT) begin
            step();
            budget++;
        end
        if (!btn_per_ready_o) begin
            tests++;
            fails++;
            $display("FAIL ready_timeout: ready still low after %0d cycles", budget);
        end else begin
            clear_i = clr;
            model_accept(per, clr);
        end
        step();
        btn_per_valid_i = 1'b0;
        clear_i         = 1'b0;
    endtask

    task automatic wait_result();
        int budget = 0;
        while (cyc <= hs_cyc + LAT - 1 && budget < 4 * LAT) begin
            step();
            budget++;
        end
    endtask

    task automatic lit(input string name, input int bpm, input bit hi, input bit lo);
        check({name, "_bpm"}, bpm_o, bpm);
        check({name, "_hi"}, sat_hi_o, hi);
        check({name, "_lo"}, sat_lo_o, lo);
        check({name, "_model"}, held_bpm, bpm);
    endtask

    task automatic clear_idle();
        clear_i = 1'b1;
        hist.delete();
        clr_pend = 1'b0;
        step();
        clear_i = 1'b0;
    endtask

    task automatic mid_clear(input int k);
        while (cyc < hs_cyc + k - 1) step();
        clear_i  = 1'b1;
        clr_pend = 1'b1;
        step();
        clear_i  = 1'b0;
    endtask

    task automatic mid_reset(input int k);
        while (cyc < hs_cyc + k - 1) step();
        rst_n_i = 1'b0;
        model_reset();
        step();
        rst_n_i = 1'b1;
    endtask

    initial begin
        #(CLK_PER_NS * 25000);
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bpm;
        bit hi, lo;

        // Model pins: hand-computed conversions.
        ref_bpm(2929, bpm, hi, lo);  check("pin_2929", bpm, 100);
        ref_bpm(2563, bpm, hi, lo);  check("pin_2563", bpm, 114);
        ref_bpm(1171, bpm, hi, lo);  check("pin_1171", {bpm, hi}, {32'd250, 1'b0});
        ref_bpm(1000, bpm, hi, lo);  check("pin_1000", {bpm, hi}, {32'd250, 1'b1});
        ref_bpm(0, bpm, hi, lo);     check("pin_zero", {bpm, hi}, {32'd250, 1'b1});
        ref_bpm(20000, bpm, hi, lo); check("pin_20000", {bpm, lo}, {32'd30, 1'b1});

        // Reset; the compare process checks reset values while rst_n_i is low.
        step();
        chk_en = 1'b1;
        step();
        step();
        rst_n_i = 1'b1;
        step();

        // Basic conversion and latency.
        clear_idle();
        send(2929, 1'b0);  wait_result();  lit("t1", 100, 1'b0, 1'b0);
        send(1465, 1'b0);  wait_result();  lit("t2a", 114, 1'b0, 1'b0);
        send(1171, 1'b1);  wait_result();  lit("t2b", 250, 1'b0, 1'b0);

        // Saturation and divide-by-zero.
        send(1000, 1'b1);  wait_result();  lit("t3a", 250, 1'b1, 1'b0);
        send(0, 1'b1);     wait_result();  lit("t3b", 250, 1'b1, 1'b0);
        send(20000, 1'b1); wait_result();  lit("t3c", 30, 1'b0, 1'b1);

        // Pointer wrap; valid held high during busy is taken once, after ready.
        for (int i = 0; i < 8; i++) send($urandom_range(1500, 4000), 1'b0);
        wait_result();

        // Clear during computation: old result emitted, next sample prefills.
        send(1000, 1'b1);
        send(3000, 1'b0);
        mid_clear(10);
        wait_result();
        send(2929, 1'b0);  wait_result();  lit("t5", 100, 1'b0, 1'b0);

        // Reset during computation.
        send(1465, 1'b0);
        mid_reset(12);
        step();
        send(20000, 1'b0); wait_result();  lit("t6", 30, 1'b0, 1'b1);

        // Randomized traffic against the model.
        for (int n = 0; n < 60; n++) begin
            int per, r;
            r = $urandom_range(0, 99);
            if (r < 5)       per = 0;
            else if (r < 15) per = $urandom_range(1, 1200);
            else if (r < 25) per = $urandom_range(200000, 524287);
            else             per = $urandom_range(1000, 30000);
            send(per, ($urandom_range(0, 7) == 0));
            r = $urandom_range(0, 19);
            if (r < 3)       mid_clear($urandom_range(1, LAT));
            else if (r == 3) mid_reset($urandom_range(1, LAT - 1));
            else if (r == 4) begin
                wait_result();
                clear_idle();
            end
            repeat ($urandom_range(0, 2)) step();
        end
        wait_result();
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
